// File: rtl/dispatch_queue.sv
// dispatch_queue: circular buffer of decoded instructions, two entries in and two out per cycle.
// Optional performance counters are enabled by defining DISPATCH_QUEUE_PERF_EN.

module dispatch_queue_checker #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input logic             clk,
  input logic             rst,
  input logic [CNT_W-1:0] count
);

  a_count_bound: assert property (@(posedge clk) disable iff (rst) (int'(count) <= DEPTH));

endmodule

module dispatch_queue #(
  parameter  int DEPTH   = 8,
  parameter  int ENTRY_W = 256,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 pause,
  input  logic [1:0]           push_valid,
  input  logic [2*ENTRY_W-1:0] push_data,
  output logic                 push_ready,
  input  logic [1:0]           pop_en,
  output logic [1:0]           head_valid,
  output logic [2*ENTRY_W-1:0] head_data,
`ifdef DISPATCH_QUEUE_PERF_EN
  output logic [31:0]          perf_full_cycles,
  output logic [31:0]          perf_single_issue,
`endif
  output logic [PTR_W:0]       count
);

  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic [PTR_W-1:0]   w_wr_ptr_p1;
  logic [PTR_W-1:0]   w_rd_ptr_p1;
  logic               w_ready;
  logic               w_cnt_ge1;
  logic               w_cnt_ge2;
  logic               w_wr_en;
  logic [1:0]         w_npush;
  logic [1:0]         w_npop_req;
  logic [1:0]         w_npop;

  assign w_wr_ptr_p1 = r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr_p1 = r_rd_ptr + PTR_W'(1);
  assign w_ready     = (r_count <= CNT_W'(DEPTH - 2));
  assign w_cnt_ge1   = (r_count != CNT_W'(0));
  assign w_cnt_ge2   = (r_count >= CNT_W'(2));
  assign w_wr_en     = w_ready && !flush && !rst;

  // Accepted push count; ignored entirely while not ready or flushing.
  always_comb begin
    w_npush = 2'd0;
    if (w_wr_en) begin
      w_npush = {1'b0, push_valid[0]} + {1'b0, push_valid[1]};
    end else begin
      w_npush = 2'd0;
    end
  end

  // Pop count: decode issue enable, clamp to occupancy, block on pause.
  always_comb begin
    w_npop_req = 2'd0;
    w_npop     = 2'd0;
    case (pop_en)
      2'b00:        w_npop_req = 2'd0;
      2'b01, 2'b10: w_npop_req = 2'd1;
      2'b11:        w_npop_req = 2'd2;
      default:      w_npop_req = 2'd0;
    endcase
    if (pause) begin
      w_npop = 2'd0;
    end else if (!w_cnt_ge1) begin
      w_npop = 2'd0;
    end else if (!w_cnt_ge2 && (w_npop_req == 2'd2)) begin
      w_npop = 2'd1;
    end else begin
      w_npop = w_npop_req;
    end
  end

  // Pointer and occupancy state; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_npush);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_npop);
      r_count  <= r_count + CNT_W'(w_npush) - CNT_W'(w_npop);
    end
  end

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      case (push_valid)
        2'b11: begin
          r_mem[r_wr_ptr]    <= push_data[ENTRY_W-1:0];
          r_mem[w_wr_ptr_p1] <= push_data[2*ENTRY_W-1:ENTRY_W];
        end
        2'b01:   r_mem[r_wr_ptr] <= push_data[ENTRY_W-1:0];
        2'b10:   r_mem[r_wr_ptr] <= push_data[2*ENTRY_W-1:ENTRY_W];
        default: ;
      endcase
    end
  end

  // Head view; unoccupied slots read as zero so stale storage never leaks.
  always_comb begin
    head_data = '0;
    if (w_cnt_ge1) begin
      head_data[ENTRY_W-1:0] = r_mem[r_rd_ptr];
    end else begin
      head_data[ENTRY_W-1:0] = {ENTRY_W{1'b0}};
    end
    if (w_cnt_ge2) begin
      head_data[2*ENTRY_W-1:ENTRY_W] = r_mem[w_rd_ptr_p1];
    end else begin
      head_data[2*ENTRY_W-1:ENTRY_W] = {ENTRY_W{1'b0}};
    end
  end

  assign head_valid = {w_cnt_ge2, w_cnt_ge1};
  assign push_ready = w_ready;
  assign count      = r_count;

`ifdef DISPATCH_QUEUE_PERF_EN
  logic [31:0] r_perf_full;
  logic [31:0] r_perf_single;

  // Saturating event counters; cleared only by reset, they survive flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_full   <= 32'd0;
      r_perf_single <= 32'd0;
    end else begin
      if (!w_ready && (push_valid != 2'b00) && (r_perf_full != 32'hFFFF_FFFF)) begin
        r_perf_full <= r_perf_full + 32'd1;
      end else begin
        r_perf_full <= r_perf_full;
      end
      if ((w_npop == 2'd1) && w_cnt_ge2 && (r_perf_single != 32'hFFFF_FFFF)) begin
        r_perf_single <= r_perf_single + 32'd1;
      end else begin
        r_perf_single <= r_perf_single;
      end
    end
  end

  assign perf_full_cycles  = r_perf_full;
  assign perf_single_issue = r_perf_single;
`endif

  dispatch_queue_checker #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_checker (
    .clk   (clk),
    .rst   (rst),
    .count (r_count)
  );

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed self-checking bench for dispatch_queue (DEPTH=8, ENTRY_W=256).

module tb_dispatch_queue;

  localparam int EW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          pause = 1'b0;
  logic [1:0]    push_valid = 2'b00;
  logic [2*EW-1:0] push_data = '0;
  logic          push_ready;
  logic [1:0]    pop_en = 2'b00;
  logic [1:0]    head_valid;
  logic [2*EW-1:0] head_data;
  logic [3:0]    count;
`ifdef DISPATCH_QUEUE_PERF_EN
  logic [31:0]   perf_full_cycles;
  logic [31:0]   perf_single_issue;
`endif

  int n_cmp = 0;
  int n_err = 0;

  dispatch_queue #(.DEPTH(8), .ENTRY_W(EW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .pause      (pause),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop_en     (pop_en),
    .head_valid (head_valid),
    .head_data  (head_data),
`ifdef DISPATCH_QUEUE_PERF_EN
    .perf_full_cycles  (perf_full_cycles),
    .perf_single_issue (perf_single_issue),
`endif
    .count      (count)
  );

  always #5 clk = ~clk;

  function automatic logic [EW-1:0] mk(input int n);
    logic [31:0] w;
    w = 32'(n) ^ 32'hA5C3_0000;
    return {8{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1; push_valid = 2'b00; pop_en = 2'b00;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_cmp++; if (head_valid !== 2'b00) begin n_err++; $display("FAIL reset_head_valid got=%b exp=00", head_valid); end
    n_cmp++; if (head_data !== '0) begin n_err++; $display("FAIL reset_head_data got=%h exp=0", head_data[31:0]); end
    n_cmp++; if (push_ready !== 1'b1) begin n_err++; $display("FAIL reset_push_ready got=%b exp=1", push_ready); end
  endtask

  task automatic test_push_order();
    push_valid = 2'b11; push_data = {mk(2), mk(1)};
    tick();
    n_cmp++; if (count !== 4'd2) begin n_err++; $display("FAIL order_count2 got=%0d exp=2", count); end
    push_valid = 2'b01; push_data = {mk(99), mk(3)};
    tick();
    push_valid = 2'b00;
    n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL order_count3 got=%0d exp=3", count); end
    n_cmp++; if (head_data !== {mk(2), mk(1)}) begin n_err++; $display("FAIL order_head got=%h/%h exp=%h/%h", head_data[EW+31:EW], head_data[31:0], mk(2)[31:0], mk(1)[31:0]); end
    n_cmp++; if (head_valid !== 2'b11) begin n_err++; $display("FAIL order_valid got=%b exp=11", head_valid); end
    pop_en = 2'b11; tick(); pop_en = 2'b00;
    n_cmp++; if (head_data[EW-1:0] !== mk(3) || head_valid !== 2'b01) begin n_err++; $display("FAIL order_third got=%h v=%b exp=%h v=01", head_data[31:0], head_valid, mk(3)[31:0]); end
  endtask

  task automatic test_full();
    do_flush();
    for (int k = 0; k < 3; k++) begin
      push_valid = 2'b11; push_data = {mk(10 + 2*k + 1), mk(10 + 2*k)};
      tick();
    end
    n_cmp++; if (count !== 4'd6 || push_ready !== 1'b1) begin n_err++; $display("FAIL full_six got=%0d rdy=%b exp=6 rdy=1", count, push_ready); end
    push_valid = 2'b01; push_data = {mk(0), mk(16)};
    tick();
    n_cmp++; if (count !== 4'd7 || push_ready !== 1'b0) begin n_err++; $display("FAIL full_seven got=%0d rdy=%b exp=7 rdy=0", count, push_ready); end
    push_valid = 2'b11; push_data = {mk(18), mk(17)};
    tick();
    n_cmp++; if (count !== 4'd7) begin n_err++; $display("FAIL full_ignored got=%0d exp=7", count); end
    push_valid = 2'b00; pop_en = 2'b11;
    tick();
    pop_en = 2'b00;
    n_cmp++; if (count !== 4'd5 || push_ready !== 1'b1) begin n_err++; $display("FAIL full_pop got=%0d rdy=%b exp=5 rdy=1", count, push_ready); end
    n_cmp++; if (head_data !== {mk(13), mk(12)}) begin n_err++; $display("FAIL full_head got=%h/%h exp=%h/%h", head_data[EW+31:EW], head_data[31:0], mk(13)[31:0], mk(12)[31:0]); end
  endtask

  task automatic test_back_to_back();
    logic [EW-1:0] q[$];
    do_flush();
    push_valid = 2'b11; push_data = {mk(101), mk(100)};
    q.push_back(mk(100)); q.push_back(mk(101));
    tick();
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if (count !== 4'd2) begin n_err++; $display("FAIL b2b_count[%0d] got=%0d exp=2", i, count); end
      n_cmp++; if (head_data !== {q[1], q[0]}) begin n_err++; $display("FAIL b2b_head[%0d] got=%h/%h exp=%h/%h", i, head_data[EW+31:EW], head_data[31:0], q[1][31:0], q[0][31:0]); end
      push_valid = 2'b11; pop_en = 2'b11;
      push_data = {mk(102 + 2*i + 1), mk(102 + 2*i)};
      q.push_back(mk(102 + 2*i)); q.push_back(mk(102 + 2*i + 1));
      tick();
      void'(q.pop_front()); void'(q.pop_front());
    end
    push_valid = 2'b00; pop_en = 2'b00;
    n_cmp++; if (count !== 4'd2 || head_data !== {q[1], q[0]}) begin n_err++; $display("FAIL b2b_final got=%0d %h exp=2 %h", count, head_data[31:0], q[0][31:0]); end
  endtask

  task automatic test_pop_edge();
    do_flush();
    push_valid = 2'b01; push_data = {mk(0), mk(200)};
    tick();
    push_valid = 2'b00; pause = 1'b1; pop_en = 2'b11;
    tick();
    n_cmp++; if (count !== 4'd1 || head_valid !== 2'b01) begin n_err++; $display("FAIL pause_hold got=%0d v=%b exp=1 v=01", count, head_valid); end
    n_cmp++; if (head_data !== {{EW{1'b0}}, mk(200)}) begin n_err++; $display("FAIL pause_head got=%h/%h exp=0/%h", head_data[EW+31:EW], head_data[31:0], mk(200)[31:0]); end
    pause = 1'b0;
    tick();
    pop_en = 2'b00;
    n_cmp++; if (count !== 4'd0 || head_valid !== 2'b00) begin n_err++; $display("FAIL pop_clamp got=%0d v=%b exp=0 v=00", count, head_valid); end
    push_valid = 2'b11; push_data = {mk(202), mk(201)};
    tick();
    push_valid = 2'b00; pop_en = 2'b10;
    tick();
    pop_en = 2'b00;
    n_cmp++; if (count !== 4'd1 || head_data[EW-1:0] !== mk(202)) begin n_err++; $display("FAIL pop_10 got=%0d %h exp=1 %h", count, head_data[31:0], mk(202)[31:0]); end
  endtask

  task automatic test_flush();
    do_flush();
    push_valid = 2'b11; push_data = {mk(301), mk(300)}; tick();
    push_valid = 2'b11; push_data = {mk(303), mk(302)}; tick();
    push_valid = 2'b01; push_data = {mk(0), mk(304)};   tick();
    n_cmp++; if (count !== 4'd5) begin n_err++; $display("FAIL flush_pre got=%0d exp=5", count); end
    flush = 1'b1; push_valid = 2'b11; push_data = {mk(311), mk(310)};
    tick();
    flush = 1'b0; push_valid = 2'b00;
    n_cmp++; if (count !== 4'd0 || head_valid !== 2'b00 || head_data !== '0) begin n_err++; $display("FAIL flush_empty got=%0d v=%b exp=0 v=00", count, head_valid); end
    push_valid = 2'b01; push_data = {mk(0), mk(320)};
    tick();
    push_valid = 2'b00;
    n_cmp++; if (count !== 4'd1 || head_data[EW-1:0] !== mk(320)) begin n_err++; $display("FAIL flush_after got=%0d %h exp=1 %h", count, head_data[31:0], mk(320)[31:0]); end
  endtask

`ifdef DISPATCH_QUEUE_PERF_EN
  task automatic test_perf();
    n_cmp++; if (perf_full_cycles !== 32'd1) begin n_err++; $display("FAIL perf_full got=%0d exp=1", perf_full_cycles); end
    n_cmp++; if (perf_single_issue !== 32'd1) begin n_err++; $display("FAIL perf_single got=%0d exp=1", perf_single_issue); end
  endtask
`endif

  initial begin
    test_reset();
    test_push_order();
    test_full();
    test_back_to_back();
    test_pop_edge();
    test_flush();
`ifdef DISPATCH_QUEUE_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
